// File: rtl/seq_mult32_pkg.sv
// seq_mult32_pkg: shared constants and FSM state encoding for the sequential multiplier.
package seq_mult32_pkg;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITER = 32;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder32.sv
// adder32: 32-bit ripple-free behavioural adder with carry in/out.
module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_in_i,
  output logic [31:0] sum_o,
  output logic        c_out_o
);
  assign {c_out_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, c_in_i};
endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: start/busy/done FSM and iteration counter for seq_mult32.
module mult_ctrl
  import seq_mult32_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic step
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    load = start && (state_q != S_RUN);
    step = state_q == S_RUN;
    busy = step;
    done = state_q == S_DONE;
    if (load) begin
      state_d = S_RUN;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      state_d = (cnt_q == CNT_LAST) ? S_DONE : S_RUN;
    end else if (done) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/seq_mult32.sv
// seq_mult32: 32x32->64 shift-and-add multiplier, one adder32 step per cycle.
// Define SIGNED_MUL_EN for radix-2 Booth two's-complement operation.
module seq_mult32
  import seq_mult32_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MUL_WIDTH-1:0]   mcand,
  input  logic [MUL_WIDTH-1:0]   mplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*MUL_WIDTH-1:0] product
);
  logic load, step, c_in, c_out, shift_in;
  logic [MUL_WIDTH-1:0] m_q, hi_q, lo_q, b, sum;
  mult_ctrl u_ctrl (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .busy (busy),
    .done (done),
    .load (load),
    .step (step)
  );
`ifdef SIGNED_MUL_EN
  logic qp_q;
  logic [1:0] sel;
  assign sel = {lo_q[0], qp_q};
  assign b = (sel == 2'b01) ? m_q : (sel == 2'b10) ? ~m_q : '0;
  assign c_in = sel == 2'b10;
  // true 33-bit sign of hi+B, so the most negative multiplicand shifts correctly
  assign shift_in = hi_q[MUL_WIDTH-1] ^ b[MUL_WIDTH-1] ^ c_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qp_q <= 1'b0;
    else if (load) qp_q <= 1'b0;
    else if (step) qp_q <= lo_q[0];
  end
`else
  assign b = lo_q[0] ? m_q : '0;
  assign c_in = 1'b0;
  assign shift_in = c_out;
`endif
  adder32 u_add (
    .a_i    (hi_q),
    .b_i    (b),
    .c_in_i (c_in),
    .sum_o  (sum),
    .c_out_o(c_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (load) begin
      m_q <= mcand;
      hi_q <= '0;
      lo_q <= mplier;
    end else if (step) begin
      {hi_q, lo_q} <= {shift_in, sum, lo_q[MUL_WIDTH-1:1]};
    end
  end
  assign product = {hi_q, lo_q};
endmodule
